// File: rtl/ebi_pkg.sv
// Shared types and constants for the EBI/SMC register-file slave.
package ebi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StRead,
    StWrite,
    StError,
    StDone
  } ebi_state_e;

  localparam int unsigned REG_ID  = 0;
  localparam int unsigned REG_CNT = 1;
  localparam int unsigned CNT_W   = 8;

  localparam logic [15:0] ID_VALUE_DEFAULT = 16'hDEFA;

endpackage

// File: rtl/ebi_sync.sv
// Width-parametrised multi-stage flop chain used to bring host pins into the fabric clock.
module ebi_sync #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ebi_regfile_slave.sv
// Static-memory bus slave: synchronises host strobes and serves an ID word, access/error
// counters and NUM_REGS-2 read/write control registers with per-register write pulses.
module ebi_regfile_slave
  import ebi_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 25,
  parameter int unsigned       NUM_REGS    = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(ID_VALUE_DEFAULT)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  inout  wire  [DATA_W-1:0]              data_io,
  input  logic [ADDR_W-1:0]              addr_i,
  input  logic                           read_i,
  input  logic                           write_i,
  input  logic                           cs_i,
  output logic [(NUM_REGS-2)*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-2-1:0]          wr_pulse_o,
  output logic [4:0]                     leds_o
);

  localparam int unsigned IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned NUM_CTRL = NUM_REGS - 2;
  localparam int unsigned SYNC_W   = 3 + IDX_W + DATA_W;

  // Strobes idle high out of reset so the FSM does not see a phantom access.
  localparam logic [SYNC_W-1:0] SYNC_RESET = {3'b111, {(IDX_W + DATA_W){1'b0}}};

  logic [SYNC_W-1:0] sync_in, sync_out;
  logic              cs_s, rd_s, wr_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] data_s;

  // Upper address bits and the byte bit never select a register.
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_W-1:IDX_W+1], addr_i[0]};

  assign sync_in = {cs_i, read_i, write_i, addr_i[IDX_W:1], data_io};

  ebi_sync #(
    .WIDTH     (SYNC_W),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (SYNC_RESET)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (reset_i),
    .d_i    (sync_in),
    .q_o    (sync_out)
  );

  assign {cs_s, rd_s, wr_s, idx_s, data_s} = sync_out;

  ebi_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  acc_q, err_q;
  logic [DATA_W-1:0] ctrl_q [NUM_CTRL];
  logic [NUM_CTRL-1:0] wr_pulse_q, wr_sel;
  logic [DATA_W-1:0] reg_view [NUM_REGS];
  logic              commit, acc_inc, err_inc;

  always_comb begin
    reg_view[REG_ID]  = ID_VALUE;
    reg_view[REG_CNT] = DATA_W'({err_q, acc_q});
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      reg_view[i+2] = ctrl_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_out_d = data_out_q;
    commit     = 1'b0;
    acc_inc    = 1'b0;
    err_inc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!cs_s) begin
          state_d = StDecode;
          idx_d   = idx_s;
        end
      end
      StDecode: begin
        if (cs_s) begin
          state_d = StIdle;
        end else if (!rd_s && !wr_s) begin
          state_d = StError;
        end else if (!rd_s) begin
          state_d    = StRead;
          data_out_d = reg_view[idx_q];
        end else if (!wr_s) begin
          state_d = StWrite;
        end
      end
      StRead: begin
        if (rd_s || cs_s) begin
          state_d = StDone;
          acc_inc = 1'b1;
        end
      end
      StWrite: begin
        // Strobe was low on entry, so any high sample here is the rising edge.
        if (wr_s) begin
          state_d = StDone;
          commit  = 1'b1;
          acc_inc = 1'b1;
        end else if (cs_s) begin
          state_d = StDone;
          err_inc = 1'b1;
        end
      end
      StError: begin
        state_d = StDone;
        err_inc = 1'b1;
      end
      StDone: begin
        if (cs_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      wr_sel[i] = commit && (idx_q == IDX_W'(i + 2));
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      data_out_q <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      wdata_q    <= data_s;
      if (acc_inc) begin
        acc_q <= acc_q + 1'b1;
      end
      if (err_inc) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_pulse_q <= '0;
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        ctrl_q[i] <= '0;
      end
    end else begin
      wr_pulse_q <= wr_sel;
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        if (wr_sel[i]) begin
          ctrl_q[i] <= wdata_q;
        end
      end
    end
  end

  // Drive qualified by the raw pins so the bus frees up as soon as the host lets go.
  assign data_io = (!cs_i && !read_i && (state_q == StRead)) ? data_out_q : 'z;

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_regs
    assign regs_o[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

  assign wr_pulse_o = wr_pulse_q;
  assign leds_o     = ctrl_q[0][4:0];

endmodule

// File: tb/tb_ebi_regfile_slave.sv
// Scoreboard bench: host tasks push expected bus/regfile responses, a monitor checks them.
module tb_ebi_regfile_slave;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ADDR_W      = 25;
  localparam int unsigned NUM_REGS    = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned NUM_CTRL    = NUM_REGS - 2;
  localparam int unsigned RD_SAMPLE   = SYNC_STAGES + 3;
  localparam logic [DATA_W-1:0] ID_WORD = 16'hDEFA;
  localparam logic [DATA_W-1:0] BUS_IDLE = '1;

  typedef struct packed {
    logic [NUM_CTRL-1:0]        pulse;
    logic [NUM_CTRL*DATA_W-1:0] regs;
    logic [4:0]                 leds;
  } wr_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset_n;
  logic [ADDR_W-1:0]          addr;
  logic                       rd_n, wr_n, cs_n;
  logic                       host_oe;
  logic [DATA_W-1:0]          host_data;
  wire  [DATA_W-1:0]          bus;
  logic [NUM_CTRL*DATA_W-1:0] regs;
  logic [NUM_CTRL-1:0]        pulse;
  logic [4:0]                 leds;

  assign bus = host_oe ? host_data : 'z;
  for (genvar g = 0; g < DATA_W; g++) begin : g_pu
    pullup (bus[g]);
  end

  ebi_regfile_slave #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .NUM_REGS    (NUM_REGS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_n),
    .data_io    (bus),
    .addr_i     (addr),
    .read_i     (rd_n),
    .write_i    (wr_n),
    .cs_i       (cs_n),
    .regs_o     (regs),
    .wr_pulse_o (pulse),
    .leds_o     (leds)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] rd_q [$];
  wr_exp_t           wr_q [$];

  // Reference model: plain register array plus two modulo-256 counters.
  logic [DATA_W-1:0] m_reg [NUM_REGS];
  int                m_acc, m_err;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_reg[i] = '0;
    m_acc = 0;
    m_err = 0;
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int idx);
    logic [7:0] a, e;
    a = 8'(m_acc % 256);
    e = 8'(m_err % 256);
    if (idx == 0) return ID_WORD;
    if (idx == 1) return {e, a};
    return m_reg[idx];
  endfunction

  function automatic wr_exp_t model_snapshot(input int idx);
    wr_exp_t w;
    w.pulse = '0;
    w.pulse[idx-2] = 1'b1;
    for (int i = 0; i < NUM_CTRL; i++) w.regs[i*DATA_W +: DATA_W] = m_reg[i+2];
    w.leds = m_reg[2][4:0];
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input int hold);
    rd_q.push_back(model_read(int'(a[3:1])));
    m_acc++;
    addr = a;
    cs_n = 1'b0;
    tick(1);
    rd_n = 1'b0;
    tick(hold);
    rd_n = 1'b1;
    tick(1);
    cs_n = 1'b1;
    tick(4);
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int idx;
    idx = int'(a[3:1]);
    m_acc++;
    if (idx >= 2) begin
      m_reg[idx] = d;
      wr_q.push_back(model_snapshot(idx));
    end
    addr      = a;
    host_data = d;
    host_oe   = 1'b1;
    cs_n      = 1'b0;
    tick(1);
    wr_n = 1'b0;
    tick(6);
    wr_n = 1'b1;
    tick(1);
    cs_n    = 1'b1;
    host_oe = 1'b0;
    tick(5);
  endtask

  task automatic host_error(input logic [ADDR_W-1:0] a);
    rd_q.push_back(BUS_IDLE);
    m_err++;
    addr = a;
    cs_n = 1'b0;
    tick(1);
    rd_n = 1'b0;
    wr_n = 1'b0;
    tick(7);
    rd_n = 1'b1;
    wr_n = 1'b1;
    tick(1);
    cs_n = 1'b1;
    tick(5);
  endtask

  task automatic host_abort(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    m_err++;
    addr      = a;
    host_data = d;
    host_oe   = 1'b1;
    cs_n      = 1'b0;
    tick(1);
    wr_n = 1'b0;
    tick(4);
    cs_n = 1'b1;
    tick(3);
    wr_n    = 1'b1;
    host_oe = 1'b0;
    tick(4);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr(input int idx);
    logic [ADDR_W-1:0] a;
    logic [2:0]        ix;
    a     = ADDR_W'($urandom);
    ix    = 3'(idx);
    a[3:1] = ix;
    return a;
  endfunction

  // Monitor: reads sampled at a fixed depth into the strobe, write pulses checked as they appear.
  initial begin : monitor
    int                low_cnt;
    logic [DATA_W-1:0] exp_rd;
    wr_exp_t           exp_wr;
    low_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset_n && !cs_n && !rd_n) low_cnt++;
      else low_cnt = 0;
      if (low_cnt == RD_SAMPLE) begin
        if (rd_q.size() == 0) begin
          check("read_unexpected", 1, 0);
        end else begin
          exp_rd = rd_q.pop_front();
          check("read_data", bus, exp_rd);
        end
      end
      if (reset_n && rd_n && !host_oe) check("bus_released", bus, BUS_IDLE);
      if (pulse != '0) begin
        if (wr_q.size() == 0) begin
          check("wr_pulse_unexpected", pulse, 0);
        end else begin
          exp_wr = wr_q.pop_front();
          check("wr_pulse", pulse, exp_wr.pulse);
          check("regs_after_write", regs, exp_wr.regs);
          check("leds_after_write", leds, exp_wr.leds);
        end
      end
    end
  end

  initial begin : stimulus
    int op;
    model_reset();
    reset_n   = 1'b0;
    addr      = '0;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    cs_n      = 1'b1;
    host_oe   = 1'b0;
    host_data = '0;
    tick(3);
    check("reset_regs", regs, 0);
    check("reset_pulse", pulse, 0);
    check("reset_leds", leds, 0);
    check("reset_bus", bus, BUS_IDLE);
    reset_n = 1'b1;
    tick(3);

    host_read(25'h0, 8);
    host_read(25'h2, 8);
    host_write(25'h4, 16'h1234);
    check("leds_0x14", leds, 5'h14);
    host_read(25'h4, 8);
    host_read(25'h2, 8);
    host_error(25'h6);
    host_read(25'h2, 8);
    host_abort(25'h8, 16'h5555);
    host_read(25'h8, 8);
    host_write(25'h0, 16'hFFFF);
    host_read(25'h0, 8);
    host_read(25'h2, 8);

    for (int i = 0; i < 50; i++) begin
      op = int'($urandom_range(0, 19));
      if (op < 8) host_read(rand_addr(int'($urandom_range(0, NUM_REGS - 1))),
                            int'($urandom_range(6, 10)));
      else if (op < 16) host_write(rand_addr(int'($urandom_range(0, NUM_REGS - 1))),
                                   DATA_W'($urandom));
      else if (op < 18) host_error(rand_addr(int'($urandom_range(0, NUM_REGS - 1))));
      else host_abort(rand_addr(int'($urandom_range(2, NUM_REGS - 1))), DATA_W'($urandom));
    end
    host_read(25'h2, 8);

    // Reset while the slave is driving a read.
    host_write(25'h4, 16'h00A5);
    rd_q.push_back(model_read(2));
    addr = 25'h4;
    cs_n = 1'b0;
    tick(1);
    rd_n = 1'b0;
    tick(6);
    reset_n = 1'b0;
    #1;
    check("reset_mid_read_bus", bus, BUS_IDLE);
    check("reset_mid_read_regs", regs, 0);
    check("reset_mid_read_leds", leds, 0);
    model_reset();
    rd_n = 1'b1;
    cs_n = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    host_read(25'h2, 8);
    host_read(25'h0, 8);
    host_write(25'hE, 16'hBEEF);
    host_read(25'hE, 8);

    tick(10);
    check("read_queue_drained", rd_q.size(), 0);
    check("write_queue_drained", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
